// File: rtl/coord_mux4.sv
// rtl/coord_mux4.sv - registered 4:1 coordinate-pair selector (optional COORD_MUX_AUTOSCAN_EN)
module coord_mux4 #(
    parameter int X_W = 11,
    parameter int Y_W = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    input  logic [X_W-1:0] x2,
    input  logic [Y_W-1:0] y2,
    input  logic [X_W-1:0] x3,
    input  logic [Y_W-1:0] y3,
    input  logic [X_W-1:0] x4,
    input  logic [Y_W-1:0] y4,
    input  logic [1:0]     selector,
    input  logic           auto_scan,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic [1:0]     out_sel,
    output logic           out_valid
);

    logic [1:0]     eff_sel;
    logic [X_W-1:0] mux_x;
    logic [Y_W-1:0] mux_y;

`ifdef COORD_MUX_AUTOSCAN_EN
    logic [1:0] scan_cnt;

    // Scan counter steps through the sources on every enabled edge while auto-scanning
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= 2'd0;
        end else if (en && auto_scan) begin
            scan_cnt <= scan_cnt + 2'd1;
        end
    end

    assign eff_sel = auto_scan ? scan_cnt : selector;
`else
    logic unused_auto_scan;

    assign unused_auto_scan = auto_scan;
    assign eff_sel          = selector;
`endif

    // X and Y come from one case arm so a mixed pair can never be formed
    always_comb begin
        mux_x = x1;
        mux_y = y1;
        case (eff_sel)
            2'd0: begin mux_x = x1; mux_y = y1; end
            2'd1: begin mux_x = x2; mux_y = y2; end
            2'd2: begin mux_x = x3; mux_y = y3; end
            2'd3: begin mux_x = x4; mux_y = y4; end
        endcase
    end

    // Output registers load on enable and otherwise hold; valid is sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_x     <= '0;
            out_y     <= '0;
            out_sel   <= 2'd0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_x     <= mux_x;
            out_y     <= mux_y;
            out_sel   <= eff_sel;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_coord_mux4.sv
// tb/tb_coord_mux4.sv - scoreboard testbench for coord_mux4
module tb_coord_mux4;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef struct {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [1:0]     sel;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           en = 1'b0;
    logic [X_W-1:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;
    logic [Y_W-1:0] y1 = '0, y2 = '0, y3 = '0, y4 = '0;
    logic [1:0]     selector = 2'd0;
    logic           auto_scan = 1'b0;
    logic [X_W-1:0] out_x;
    logic [Y_W-1:0] out_y;
    logic [1:0]     out_sel;
    logic           out_valid;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    coord_mux4 #(.X_W(X_W), .Y_W(Y_W)) dut (
        .clk(clk), .reset(reset), .en(en),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .x3(x3), .y3(y3), .x4(x4), .y4(y4),
        .selector(selector), .auto_scan(auto_scan),
        .out_x(out_x), .out_y(out_y), .out_sel(out_sel), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_pairs(input int ax1, ay1, ax2, ay2, ax3, ay3, ax4, ay4);
        x1 = X_W'(ax1); y1 = Y_W'(ay1);
        x2 = X_W'(ax2); y2 = Y_W'(ay2);
        x3 = X_W'(ax3); y3 = Y_W'(ay3);
        x4 = X_W'(ax4); y4 = Y_W'(ay4);
    endtask

    task automatic push_exp(input int ex, input int ey, input int es);
        exp_t e;
        e.x = X_W'(ex); e.y = Y_W'(ey); e.sel = 2'(es);
        exp_q.push_back(e);
    endtask

    // Monitor: every enabled edge is a capture; pop one expectation and compare
    always @(posedge clk) begin
        logic cap;
        exp_t e;
        cap = en && !reset;
        #1;
        if (cap) begin
            if (exp_q.size() == 0) begin
                check("unexpected_capture", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_x", 32'(out_x), 32'(e.x));
                check("out_y", 32'(out_y), 32'(e.y));
                check("out_sel", 32'(out_sel), 32'(e.sel));
                check("out_valid", 32'(out_valid), 32'd1);
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_x", 32'(out_x), 32'd0);
        check("rst_y", 32'(out_y), 32'd0);
        check("rst_sel", 32'(out_sel), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed captures
        set_pairs(10, 20, 23, 12, 56, 15, 20, 112);
        selector = 2'd0; en = 1'b1; push_exp(10, 20, 0);
        @(negedge clk);
        set_pairs(4, 24, 23, 12, 56, 15, 20, 112);
        selector = 2'd1; push_exp(23, 12, 1);
        @(negedge clk);
        set_pairs(4, 24, 23, 12, 153, 243, 20, 112);
        selector = 2'd2; push_exp(153, 243, 2);
        @(negedge clk);
        set_pairs(4, 24, 23, 12, 153, 243, 56, 34);
        selector = 2'd3; push_exp(56, 34, 3);
        @(negedge clk);
        set_pairs(0, 0, 1, 1, 2, 2, 2047, 1023);
        selector = 2'd3; push_exp(2047, 1023, 3);
        @(negedge clk);
        set_pairs(2047, 1023, 0, 0, 5, 6, 7, 8);
        selector = 2'd0; push_exp(2047, 1023, 0);
        @(negedge clk);
        set_pairs(0, 0, 1, 1, 2, 2, 2047, 1023);
        selector = 2'd3; push_exp(2047, 1023, 3);
        @(negedge clk);

        // Hold with en low while everything changes
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_pairs(i + 1, i + 2, i + 3, i + 4, i + 5, i + 6, i + 7, i + 8);
            selector = 2'(i);
            @(posedge clk);
            #2;
            check("hold_x", 32'(out_x), 32'd2047);
            check("hold_y", 32'(out_y), 32'd1023);
            check("hold_sel", 32'(out_sel), 32'd3);
            check("hold_valid", 32'(out_valid), 32'd1);
        end

        // Asynchronous reset between edges
        #1;
        reset = 1'b1;
        #1;
        check("async_x", 32'(out_x), 32'd0);
        check("async_y", 32'(out_y), 32'd0);
        check("async_sel", 32'(out_sel), 32'd0);
        check("async_valid", 32'(out_valid), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef COORD_MUX_AUTOSCAN_EN
        @(negedge clk);
        reset = 1'b0;
        set_pairs(10, 20, 12, 12, 23, 13, 20, 2);
        selector = 2'd2; auto_scan = 1'b1; en = 1'b1;
        push_exp(10, 20, 0);
        push_exp(12, 12, 1);
        push_exp(23, 13, 2);
        push_exp(20, 2, 3);
        push_exp(10, 20, 0);
        repeat (5) @(negedge clk);
        en = 1'b0; auto_scan = 1'b0;
`endif

        // Bounded wait for the monitor to drain the scoreboard
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coord_mux4.md
Name: coord_mux4

Overview:
- Registered 4:1 selector for screen coordinate pairs (X, Y).
- Picks one of four sprite/element coordinate sources by a 2-bit selector and presents it to downstream drawing/compare logic.
- One clock of latency, with a hold enable and an echo of the selected source index.

Parameters:
- X_W, 11, width of every X coordinate input and of out_x
- Y_W, 10, width of every Y coordinate input and of out_y

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  load enable; when high the output registers capture the selected pair
- x1  input  X_W  X coordinate of source 0
- y1  input  Y_W  Y coordinate of source 0
- x2  input  X_W  X coordinate of source 1
- y2  input  Y_W  Y coordinate of source 1
- x3  input  X_W  X coordinate of source 2
- y3  input  Y_W  Y coordinate of source 2
- x4  input  X_W  X coordinate of source 3
- y4  input  Y_W  Y coordinate of source 3
- selector  input  2  source select: 0→(x1,y1), 1→(x2,y2), 2→(x3,y3), 3→(x4,y4)
- auto_scan  input  1  auto-scan request; used only when the optional feature is compiled in, otherwise ignored
- out_x  output  X_W  registered selected X coordinate
- out_y  output  Y_W  registered selected Y coordinate
- out_sel  output  2  index of the source currently held in out_x/out_y
- out_valid  output  1  high once at least one capture has occurred since reset

Behaviour:
- Reset (asynchronous, active-high) forces:
  - out_x = 0, out_y = 0, out_sel = 0, out_valid = 0
  - scan counter = 0 (when the optional feature is present)
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge.
- On each rising clk edge with reset low and en high:
  - out_x/out_y ← pair addressed by the effective select
  - out_sel ← effective select
  - out_valid ← 1
- With en low, all outputs hold their values.
- Latency: a select or data change is visible exactly one clk edge later. There is no combinational path from inputs to outputs.
- Effective select = selector, except in auto-scan mode (see Optional Feature).
- All four selector codes are legal; there is no default or X case.
- Data passes unmodified at full width: no clamping, no sign extension, no arithmetic. Extreme values such as 2047 and 1023 must pass through unchanged.
- X and Y are always taken from the same source in the same cycle; a mixed pair is never allowed.
- No handshake beyond en; out_valid never deasserts except by reset.

Optional Feature:
- Macro: COORD_MUX_AUTOSCAN_EN.
- Defined:
  - A 2-bit scan counter exists.
  - When auto_scan = 1, the effective select is the counter value.
  - The counter increments by 1 on every enabled edge (en = 1), wrapping 3→0.
  - When auto_scan = 0, selector is used and the counter holds.
  - The counter resets to 0.
- Not defined: auto_scan is ignored, no counter exists, and the effective select is always selector.

Test Plan:
- reset=1, then release; en=1, selector=0, (x1,y1)=(10,20) → after 1 edge out_x=10, out_y=20, out_sel=0, out_valid=1; during reset all outputs 0.
- selector=1, (x2,y2)=(23,12), other pairs distinct (4/24, 56/15, 20/112) → next edge out=(23,12), out_sel=1.
- selector=2, (x3,y3)=(153,243) → (153,243); then selector=3, (x4,y4)=(56,34) → (56,34), out_sel=3.
- Width limits: x4=2047, y4=1023, selector=3 → out=(2047,1023), with no truncation.
- en=0, change selector and all inputs for 3 edges → outputs unchanged; assert reset between edges → outputs 0 immediately, with no clock edge needed.
- With COORD_MUX_AUTOSCAN_EN, auto_scan=1, en=1, inputs (10,20), (12,12), (23,13), (20,2) → successive edges give out_sel 0,1,2,3,0 and matching pairs.
